// File: rtl/cache_line_responder_if.sv
// Request/response bus between a line requester and cache_line_responder.
// The requester drives the master side; the responder sits on the slave side.
interface cache_line_responder_if;
  logic         request;
  logic         wrenable;
  logic [63:0]  addr;
  logic [511:0] wdata;
  logic         reqack;
  logic [511:0] rdata;
  logic         done;
  logic         err;

  modport master (
    output request, wrenable, addr, wdata,
    input  reqack, rdata, done, err
  );

  modport slave (
    input  request, wrenable, addr, wdata,
    output reqack, rdata, done, err
  );
endinterface

// File: rtl/cache_line_responder.sv
// Single-line request responder backed by a local 512-bit line store.
// Accepts one request at a time: reqack pulse, fixed latency, then done pulse.
module cache_line_responder #(
  parameter int unsigned LINE_DEPTH   = 64,
  parameter int unsigned RESP_LATENCY = 4,
  parameter logic [63:0] BASE_ADDR    = 64'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  cache_line_responder_if.slave  bus
);

  localparam int unsigned LINE_W    = 512;
  localparam int unsigned IDX_W     = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
  localparam logic [3:0]  CNT_LAST  = 4'((RESP_LATENCY >= 2) ? (RESP_LATENCY - 2) : 0);
  localparam bit          SKIP_WAIT = (RESP_LATENCY == 1);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_reqack;
  logic                r_done;
  logic                r_err;
  logic [LINE_W-1:0]   r_rdata;

  logic                r_we;
  logic                r_inr;
  logic [IDX_W-1:0]    r_idx;
  logic [LINE_W-1:0]   r_wdata;
  logic [LINE_W-1:0]   r_mem [LINE_DEPTH];

  logic [58:0]         w_line;
  logic                w_in_range;
  logic                w_accept;
  logic                w_finish;
  logic                w_unused_lsb;

  // Line-granular offset; the extra MSB catches addresses below BASE_ADDR.
  assign w_line       = {1'b0, bus.addr[63:6]} - {1'b0, BASE_ADDR[63:6]};
  assign w_in_range   = !w_line[58] && (w_line[57:0] < 58'(LINE_DEPTH));
  assign w_unused_lsb = &{1'b0, bus.addr[5:0]};

  assign w_accept = (r_state == S_IDLE) && bus.request;
  assign w_finish = SKIP_WAIT ? (r_state == S_ACK)
                              : ((r_state == S_WAIT) && (r_cnt == CNT_LAST));

  // Operation payload snapshot, frozen from acceptance until the next one.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= bus.wrenable;
      r_inr   <= w_in_range;
      r_idx   <= w_line[IDX_W-1:0];
      r_wdata <= bus.wdata;
    end
  end

  // Store is never reset; writes land on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (w_finish && r_we && r_inr) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_reqack <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_reqack <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.request) begin
            r_state  <= S_ACK;
            r_reqack <= 1'b1;
          end
        end
        S_ACK: begin
          r_cnt   <= 4'd0;
          r_state <= S_WAIT;
        end
        S_WAIT:  r_cnt <= r_cnt + 4'd1;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      // Completion overrides the per-state transition out of ACK/WAIT.
      if (w_finish) begin
        r_state <= S_DONE;
        r_done  <= 1'b1;
        r_err   <= !r_inr;
        r_rdata <= (r_inr && !r_we) ? r_mem[r_idx] : '0;
      end
    end
  end

  assign bus.reqack = r_reqack;
  assign bus.done   = r_done;
  assign bus.err    = r_err;
  assign bus.rdata  = r_rdata;

endmodule

// File: tb/tb_cache_line_responder.sv
// Directed bench for cache_line_responder: default-parameter instance plus a
// RESP_LATENCY=1, LINE_DEPTH=4 instance sharing clock, reset and payload.
module tb_cache_line_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cache_line_responder_if bus0 ();
  cache_line_responder_if bus1 ();

  logic         req = 1'b0;
  logic         sel = 1'b0;
  logic         we = 1'b0;
  logic [63:0]  addr = '0;
  logic [511:0] wdata = '0;

  assign bus0.request  = req & ~sel;
  assign bus1.request  = req & sel;
  assign bus0.wrenable = we;
  assign bus1.wrenable = we;
  assign bus0.addr     = addr;
  assign bus1.addr     = addr;
  assign bus0.wdata    = wdata;
  assign bus1.wdata    = wdata;

  logic         ack, done, err;
  logic [511:0] rdata;
  assign ack   = sel ? bus1.reqack : bus0.reqack;
  assign done  = sel ? bus1.done   : bus0.done;
  assign err   = sel ? bus1.err    : bus0.err;
  assign rdata = sel ? bus1.rdata  : bus0.rdata;

  cache_line_responder dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  cache_line_responder #(
    .LINE_DEPTH   (4),
    .RESP_LATENCY (1),
    .BASE_ADDR    (64'h0)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  localparam logic [511:0] D_A5  = {64{8'hA5}};
  localparam logic [511:0] D_5A  = {64{8'h5A}};
  localparam logic [511:0] D_80  = {16{32'h8080_0002}};
  localparam logic [511:0] D_C0  = {16{32'hC0C0_0003}};
  localparam logic [511:0] D_FC0 = {16{32'hFCFC_003F}};
  localparam logic [511:0] D_NEW = {16{32'hDEAD_BEEF}};
  localparam logic [511:0] D_L0  = {16{32'h0123_4567}};
  localparam logic [511:0] D_L3  = {16{32'h89AB_CDEF}};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] line_of(input logic [63:0] a);
    case (a[63:6])
      58'd1:   line_of = D_A5;
      58'd2:   line_of = D_80;
      58'd3:   line_of = D_C0;
      default: line_of = '0;
    endcase
  endfunction

  // One full transaction on the selected instance, scrambling inputs after acceptance.
  task automatic op(input string tag, input logic w, input logic [63:0] a,
                    input logic [511:0] wd, input logic [511:0] exp_rd, input logic exp_err);
    int  t0, t_ack, t_done, lat;
    bit  seen;
    lat = sel ? 1 : 4;
    t_ack = 0;
    t_done = 0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = wd; t0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ack) begin seen = 1'b1; t_ack = cyc; end
    end
    check_eq({tag, ".ack_seen"}, 512'(seen), 512'(1));
    check_eq({tag, ".ack_cyc"}, 512'(t_ack - t0), 512'(1));
    req = 1'b0; we = ~w; addr = ~a; wdata = ~wd;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      check_eq({tag, ".excl"}, 512'(ack & done), 512'(0));
      if (done) begin seen = 1'b1; t_done = cyc; end
    end
    check_eq({tag, ".done_seen"}, 512'(seen), 512'(1));
    check_eq({tag, ".lat"}, 512'(t_done - t_ack), 512'(lat));
    check_eq({tag, ".rdata"}, rdata, exp_rd);
    check_eq({tag, ".err"}, 512'(err), 512'(exp_err));
    @(negedge clk);
    check_eq({tag, ".done_pulse"}, 512'(done), 512'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acks, dones, last_ack, hits;
    logic [511:0] q[$];

    repeat (3) @(negedge clk);
    check_eq("rst.reqack", 512'(bus0.reqack), 512'(0));
    check_eq("rst.done", 512'(bus0.done), 512'(0));
    check_eq("rst.err", 512'(bus0.err), 512'(0));
    check_eq("rst.rdata", bus0.rdata, '0);
    reset = 1'b1;

    op("wr40", 1'b1, 64'h40, D_A5, '0, 1'b0);
    op("rd47", 1'b0, 64'h47, '0, D_A5, 1'b0);
    op("wr80", 1'b1, 64'h80, D_80, '0, 1'b0);
    op("wrC0", 1'b1, 64'hC0, D_C0, '0, 1'b0);
    op("wrFC0", 1'b1, 64'hFC0, D_FC0, '0, 1'b0);
    op("rd80", 1'b0, 64'h80, '0, D_80, 1'b0);
    op("rd1000", 1'b0, 64'h1000, '0, '0, 1'b1);
    op("wr1000", 1'b1, 64'h1000, D_5A, '0, 1'b1);
    op("rdFC0", 1'b0, 64'hFC0, '0, D_FC0, 1'b0);

    // Abort a write to 0x80 while waiting; the line must keep its old data.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 64'h80; wdata = D_NEW;
    hits = 0;
    for (int i = 0; i < 10 && hits == 0; i++) begin
      @(negedge clk);
      if (ack) hits = 1;
    end
    check_eq("abort.ack", 512'(hits), 512'(1));
    req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort.pre_done", 512'(done), 512'(0));
    reset = 1'b0;
    #1;
    check_eq("abort.reqack", 512'(bus0.reqack), 512'(0));
    check_eq("abort.done", 512'(bus0.done), 512'(0));
    check_eq("abort.err", 512'(bus0.err), 512'(0));
    check_eq("abort.rdata", bus0.rdata, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) hits++;
    end
    check_eq("abort.no_done", 512'(hits), 512'(0));
    op("rd80_after", 1'b0, 64'h80, '0, D_80, 1'b0);

    // Request held high with a moving address: reads use the address seen at acceptance.
    acks = 0; dones = 0; last_ack = -1;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 64'h40;
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      check_eq("hold.excl", 512'(ack & done), 512'(0));
      if (ack) begin
        acks++;
        if (last_ack >= 0) check_eq("hold.gap", 512'(k - last_ack), 512'(6));
        last_ack = k;
        q.push_back(line_of(addr));
      end
      if (done) begin
        dones++;
        if (q.size() > 0) check_eq("hold.rdata", rdata, q.pop_front());
        check_eq("hold.err", 512'(err), 512'(0));
      end
      if (k == 40) req = 1'b0;
      addr = 64'(64 * (1 + (k % 3)) + (k % 64));
    end
    check_eq("hold.acks", 512'(acks), 512'(7));
    check_eq("hold.dones", 512'(dones), 512'(7));

    sel = 1'b1;
    op("l1.wr0", 1'b1, 64'h0, D_L0, '0, 1'b0);
    op("l1.rd0", 1'b0, 64'h0, '0, D_L0, 1'b0);
    op("l1.wrC0", 1'b1, 64'hC0, D_L3, '0, 1'b0);
    op("l1.rdC5", 1'b0, 64'hC5, '0, D_L3, 1'b0);
    op("l1.rd100", 1'b0, 64'h100, '0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_line_responder.md
CACHE_LINE_RESPONDER -- requirements
Module: cache_line_responder

Interface
REQ-001 SHALL have parameter LINE_DEPTH, default 64, meaning number of 512-bit lines in local store (power of 2, 2..1024).
REQ-002 SHALL have parameter RESP_LATENCY, default 4, meaning cycles from reqack to done (1..15).
REQ-003 SHALL have parameter BASE_ADDR, default 64'h0, meaning byte address of line 0 (64-byte aligned).
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port request  in  1  requester asserts and holds until reqack.
REQ-007 SHALL have port wrenable  in  1  1 = line write, 0 = line read; valid with request.
REQ-008 SHALL have port addr  in  64  byte address; addr[5:0] ignored.
REQ-009 SHALL have port wdata  in  512  write line; valid with request.
REQ-010 SHALL have port reqack  out  1  one-cycle acceptance pulse.
REQ-011 SHALL have port rdata  out  512  read line; valid in done cycle and held until next done.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port err  out  1  out-of-range flag; valid with done, held until next done.

Function
REQ-014 SHALL implement FSM states IDLE, ACK, WAIT, DONE.
REQ-015 IDLE: request sampled 1 at edge N SHALL latch addr, wrenable, wdata and enter ACK.
REQ-016 ACK SHALL drive reqack=1 for exactly one cycle (cycle N+1), then enter WAIT.
REQ-017 WAIT SHALL count RESP_LATENCY-1 cycles with a 4-bit counter, then enter DONE; RESP_LATENCY=1 goes ACK->DONE directly.
REQ-018 DONE SHALL drive done=1 for exactly one cycle (cycle N+1+RESP_LATENCY), then enter IDLE.
REQ-019 Line index SHALL be (addr - BASE_ADDR)>>6; in range iff addr >= BASE_ADDR and index < LINE_DEPTH.
REQ-020 In-range read SHALL present stored line on rdata with err=0.
REQ-021 In-range write SHALL update the line at the DONE edge, rdata=0, err=0.
REQ-022 Out-of-range request SHALL complete normally with rdata=0, err=1, no store update.
REQ-023 request in ACK/WAIT/DONE SHALL be ignored; addr/wdata changes after acceptance SHALL NOT affect the operation.
REQ-024 request held high through DONE SHALL be re-sampled in the following IDLE cycle (minimum issue spacing RESP_LATENCY+2 cycles).
REQ-025 Read after write to the same line SHALL return the written data.
REQ-026 reqack and done SHALL never be high in the same cycle.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, reqack=0, done=0, err=0, rdata=0, counter=0.
REQ-028 reset mid-operation SHALL abort without done and without store update; store contents SHALL be unaffected by reset.
REQ-029 First request SHALL be accepted no earlier than the first rising edge after reset deassertion.

Verification
REQ-030 Write addr=0x40, wdata=all 0xA5, default params -> reqack cycle N+1, done cycle N+5, err=0, rdata=0.
REQ-031 Then read addr=0x47 -> done at N'+5, rdata=all 0xA5 bytes, err=0.
REQ-032 Read addr=BASE_ADDR+64*LINE_DEPTH (0x1000) -> done, err=1, rdata=0; subsequent read of 0xFC0 unchanged.
REQ-033 request held high continuously with changing addr -> one reqack per 6 cycles, each operation uses addr sampled at its acceptance.
REQ-034 Write to 0x80 then reset low in WAIT -> no done; after reset read 0x80 returns pre-write contents.
REQ-035 RESP_LATENCY=1, read 0x0 -> reqack cycle N+1, done cycle N+2, never overlapping.
